// File: rtl/ram_av_bridge.sv
// ram_av_bridge
// Avalon-MM slave front end for the byte-banked on-chip RAM. Single and burst
// reads/writes become one RAM word access per cycle. Writes have zero wait
// states. Reads stall the master for one cycle per beat and return registered
// data with avs_readdatavalid.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   avs_address         byte address; word = avs_address[a_width+1:2]
//   avs_read/avs_write  command strobes (read wins when both are high in IDLE)
//   avs_byteenable      byte lanes of a write beat
//   avs_writedata       write beat data
//   avs_burstcount      beats per burst, 0 behaves as 1
//   avs_waitrequest     stall (high while a read burst runs and during reset)
//   avs_readdata        registered read data, holds when not valid
//   avs_readdatavalid   avs_readdata carries a beat this cycle
//   ram_addr/ram_we/ram_wd  RAM address, byte write enables, write data
//   ram_rd              RAM read data, combinational from ram_addr
//
// state | meaning
// IDLE  | accepting commands; first write beat goes straight to the RAM
// WRITE | remaining beats of a write burst, addresses from addr_q
// READ  | one RAM read per cycle from addr_q, waitrequest held high
module ram_av_bridge #(
  parameter int a_width  = 7,
  parameter int bc_width = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [a_width+1:0]  avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [3:0]          avs_byteenable,
  input  logic [31:0]         avs_writedata,
  input  logic [bc_width-1:0] avs_burstcount,
  output logic                avs_waitrequest,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  output logic [a_width-1:0]  ram_addr,
  output logic [3:0]          ram_we,
  output logic [31:0]         ram_wd,
  input  logic [31:0]         ram_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [a_width-1:0]  addr_one = {{(a_width-1){1'b0}}, 1'b1};
  localparam logic [bc_width-1:0] cnt_one  = {{(bc_width-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [a_width-1:0]  addr_q, addr_d;
  logic [bc_width-1:0] cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic [a_width-1:0]  word;
  logic [bc_width-1:0] bc_eff;

  assign word   = avs_address[a_width+1:2];
  assign bc_eff = (avs_burstcount == '0) ? cnt_one : avs_burstcount;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    rvalid_d        = 1'b0;
    avs_waitrequest = 1'b0;
    ram_addr        = word;
    ram_we          = 4'b0000;
    ram_wd          = avs_writedata;

    case (state_q)
      IDLE: begin
        if (avs_read) begin
          // read has priority; a simultaneous write is dropped
          addr_d  = word;
          cnt_d   = bc_eff;
          state_d = READ;
        end else if (avs_write) begin
          ram_we = avs_byteenable;
          if (bc_eff > cnt_one) begin
            addr_d  = word + addr_one;
            cnt_d   = bc_eff - cnt_one;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        ram_addr = addr_q;
        if (avs_write) begin
          ram_we = avs_byteenable;
          addr_d = addr_q + addr_one;
          cnt_d  = cnt_q - cnt_one;
          if (cnt_q == cnt_one) state_d = IDLE;
        end
      end

      READ: begin
        avs_waitrequest = 1'b1;
        ram_addr        = addr_q;
        rdata_d         = ram_rd;
        rvalid_d        = 1'b1;
        addr_d          = addr_q + addr_one;
        cnt_d           = cnt_q - cnt_one;
        if (cnt_q == cnt_one) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // reset stalls the master and blocks RAM writes even before the edge
    if (rst) begin
      avs_waitrequest = 1'b1;
      ram_we          = 4'b0000;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_ram_av_bridge.sv
module tb_ram_av_bridge;

  localparam int AW = 7;
  localparam int BW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [3:0]    avs_byteenable = 4'h0;
  logic [31:0]   avs_writedata = '0;
  logic [BW-1:0] avs_burstcount = '0;
  logic          avs_waitrequest;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wd;
  logic [31:0]   ram_rd;

  always #5 clk = ~clk;

  ram_av_bridge #(.a_width(AW), .bc_width(BW)) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  // byte-banked RAM the bridge drives
  logic [31:0] ram_mem [DEPTH];
  logic        init_ram = 1'b1;
  int          we_edges = 0;
  assign ram_rd = ram_mem[ram_addr];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
    end
    if (ram_we != 4'h0) we_edges <= we_edges + 1;
  end

  // reference model
  typedef struct { int cyc; logic [31:0] data; } beat_t;
  logic [31:0] model_mem [DEPTH];
  beat_t       exp_q[$];
  logic [31:0] got_q[$];
  int          flush_idx = 0;
  int          busy_end = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  logic [31:0] wd [8];
  logic [3:0]  wbe [8];
  int          wstall [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // compare process: sampled 1 time unit after every rising edge
  initial begin : compare
    int          rd_idx;
    logic [31:0] last_data;
    logic        exp_v;
    logic [31:0] exp_d;
    rd_idx = 0;
    last_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_v = 1'b0;
      if (rst) begin
        last_data = '0;
      end else begin
        if (rd_idx < flush_idx) rd_idx = flush_idx;
        if (rd_idx < exp_q.size() && exp_q[rd_idx].cyc == cyc) begin
          exp_v = 1'b1;
          last_data = exp_q[rd_idx].data;
          rd_idx++;
        end
      end
      exp_d = last_data;
      chk("waitrequest", {31'b0, avs_waitrequest}, {31'b0, rst || (cyc < busy_end)});
      chk("readdatavalid", {31'b0, avs_readdatavalid}, {31'b0, exp_v});
      chk("readdata", avs_readdata, exp_d);
      if (rst) begin
        chk("ram_we_in_reset", {28'b0, ram_we}, 32'h0);
        chk("ram_addr_in_reset", {25'b0, ram_addr}, {25'b0, avs_address[AW+1:2]});
      end
      if (avs_waitrequest && !rst) wr_cnt++;
      if (avs_readdatavalid) got_q.push_back(avs_readdata);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (cyc < busy_end) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        chk("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic model_write(input logic [AW-1:0] w, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic clear_wr();
    for (int i = 0; i < 8; i++) begin
      wd[i] = '0; wbe[i] = 4'hF; wstall[i] = 0;
    end
  endtask

  task automatic do_write(input logic [AW+1:0] a, input int n, input logic [BW-1:0] bc);
    logic [AW-1:0] w;
    w = a[AW+1:2];
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int s = 0; s < wstall[i]; s++) begin
          @(negedge clk);
          avs_write = 1'b0;
          avs_writedata = $urandom;
        end
      end
      @(negedge clk);
      if (i == 0) wait_idle();
      avs_read = 1'b0;
      avs_write = 1'b1;
      avs_address = a;
      avs_burstcount = bc;
      avs_writedata = wd[i];
      avs_byteenable = wbe[i];
      model_write(w + AW'(i), wd[i], wbe[i]);
    end
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  // returns at the falling edge right after the read was accepted
  task automatic do_read(input logic [AW+1:0] a, input logic [BW-1:0] bc, input logic with_write);
    int e0;
    int n;
    logic [AW-1:0] w;
    @(negedge clk);
    wait_idle();
    avs_read = 1'b1;
    avs_write = with_write;
    avs_address = a;
    avs_burstcount = bc;
    avs_writedata = $urandom;
    avs_byteenable = 4'hF;
    w = a[AW+1:2];
    n = (bc == 0) ? 1 : int'(bc);
    e0 = cyc + 1;
    for (int k = 0; k < n; k++) begin
      beat_t bt;
      bt.cyc = e0 + k + 1;
      bt.data = model_mem[w + AW'(k)];
      exp_q.push_back(bt);
    end
    busy_end = e0 + n;
    @(negedge clk);
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    wait_idle();
  endtask

  function automatic logic [31:0] got_at(input int base, input int idx);
    if (got_q.size() > base + idx) return got_q[base + idx];
    return 32'hBAD0BAD0;
  endfunction

  task automatic mem_chk(input string nm);
    int mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram_mem[i] !== model_mem[i]) mism++;
    chk(nm, mism, 0);
  endtask

  initial begin : main
    int base;
    int e_before;
    int w_before;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    clear_wr();
    // reset with a write request pending: RAM must stay untouched
    avs_write = 1'b1; avs_byteenable = 4'hF;
    avs_address = 9'h010; avs_writedata = 32'h55555555;
    repeat (3) @(negedge clk);
    init_ram = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    avs_write = 1'b0;
    @(negedge clk);
    mem_chk("mem_after_reset");

    // 1: single write then read
    wd[0] = 32'hDEADBEEF;
    do_write(9'h010, 1, 4'd1);
    base = got_q.size(); w_before = wr_cnt;
    do_read(9'h010, 4'd1, 1'b0);
    wait_done();
    chk("t1_beats", got_q.size() - base, 1);
    chk("t1_data", got_at(base, 0), 32'hDEADBEEF);
    chk("t1_wait_cycles", wr_cnt - w_before, 1);

    // 2: partial byte enables
    wd[0] = 32'h11223344; wbe[0] = 4'b0101;
    do_write(9'h010, 1, 4'd1);
    base = got_q.size();
    do_read(9'h010, 4'd1, 1'b0);
    wait_done();
    chk("t2_data", got_at(base, 0), 32'hDE22BE44);

    // 3: stalled write burst then read burst
    clear_wr();
    for (int i = 0; i < 4; i++) wd[i] = i + 1;
    wstall[2] = 2;
    e_before = we_edges;
    do_write(9'h000, 4, 4'd4);
    repeat (2) @(negedge clk);
    chk("t3_we_edges", we_edges - e_before, 4);
    base = got_q.size(); w_before = wr_cnt;
    do_read(9'h000, 4'd4, 1'b0);
    wait_done();
    chk("t3_beats", got_q.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("t3_data", got_at(base, i), i + 1);
    chk("t3_wait_cycles", wr_cnt - w_before, 4);

    // 4: wrap at the top of the RAM, burstcount 0
    clear_wr();
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    do_write(9'h1F8, 3, 4'd3);
    base = got_q.size();
    do_read(9'h1F8, 4'd3, 1'b0);
    wait_done();
    chk("t4_data0", got_at(base, 0), 32'hA);
    chk("t4_data1", got_at(base, 1), 32'hB);
    chk("t4_data2", got_at(base, 2), 32'hC);
    base = got_q.size();
    do_read(9'h1F8, 4'd0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("t4_bc0_beats", got_q.size() - base, 1);

    // 5: reset one cycle after the 3rd beat of an 8-beat read
    base = got_q.size();
    do_read(9'h000, 4'd8, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    flush_idx = exp_q.size();
    busy_end = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_beats_before_reset", got_q.size() - base, 3);
    base = got_q.size();
    do_read(9'h010, 4'd1, 1'b0);
    wait_done();
    chk("t5_data_after_reset", got_at(base, 0), 32'hDE22BE44);

    // 6: read+write together, then write right behind a 2-beat read
    base = got_q.size();
    do_read(9'h010, 4'd1, 1'b1);
    wait_done();
    chk("t6_read_wins", got_at(base, 0), 32'hDE22BE44);
    mem_chk("t6_mem_unchanged");
    clear_wr();
    wd[0] = 32'hCAFEF00D;
    do_read(9'h000, 4'd2, 1'b0);
    do_write(9'h020, 1, 4'd1);
    base = got_q.size();
    do_read(9'h020, 4'd1, 1'b0);
    wait_done();
    chk("t6_b2b_write", got_at(base, 0), 32'hCAFEF00D);

    // randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        int n;
        logic [BW-1:0] bc;
        n = $urandom_range(1, 8);
        bc = BW'(n);
        if (n == 1 && $urandom_range(0, 1) == 1) bc = '0;
        for (int i = 0; i < 8; i++) begin
          wd[i] = $urandom;
          wbe[i] = 4'($urandom_range(0, 15));
          wstall[i] = $urandom_range(0, 2);
        end
        do_write(9'($urandom), n, bc);
      end else begin
        do_read(9'($urandom), BW'($urandom_range(0, 8)), 1'($urandom_range(0, 3) == 0));
      end
    end
    wait_done();
    repeat (3) @(negedge clk);
    mem_chk("final_mem");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
